// File: rtl/uart_defs.sv
// uart_defs: register offsets, STATUS bit positions and FSM encodings shared by serial_uart, SoC decode and bench.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package uart_defs;

  // Upper address bits [15:4] that decode to this UART.
  localparam logic [11:0] UART_BASE_HI = 12'h7F1;

  // Register offsets (memAddr[3:0]).
  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h1;

  // STATUS bit positions; bits 7:4 read as zero.
  localparam int ST_RXFULL   = 0;
  localparam int ST_TXBUSY   = 1;
  localparam int ST_OVERRUN  = 2;
  localparam int ST_FRAMEERR = 3;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Select decode used by the SoC address decoder.
  function automatic logic is_uart_addr(input logic [15:0] mem_addr);
    return mem_addr[15:4] == UART_BASE_HI;
  endfunction

endpackage

// File: rtl/serial_rx.sv
// serial_rx: 8N1 receiver -- 2-flop synchronizer, start-bit qualification, LSB-first data capture, stop check.
// Latency: byte/error pulse in the stop-sample cycle, ~3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the line falls.
// Backpressure: none; the parent must consume the one-cycle o_byte_vld / o_frame_err pulses.
// Ports: clk, reset (async active-low), i_serial (raw RX line), o_byte_vld (good byte pulse),
//        o_frame_err (bad stop bit pulse), o_byte_dat (received byte, valid with o_byte_vld).
module serial_rx
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int COUNTER_BITS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_serial,
  output logic       o_byte_vld,
  output logic       o_frame_err,
  output logic [7:0] o_byte_dat
);

  localparam logic [COUNTER_BITS-1:0] BIT_LAST  = COUNTER_BITS'(CLKS_PER_BIT - 1);
  localparam logic [COUNTER_BITS-1:0] HALF_LAST = COUNTER_BITS'(CLKS_PER_BIT / 2 - 1);

  logic                    r_sync1;
  logic                    r_sync2;
  logic                    r_line_prev;
  rx_state_t               r_state;
  rx_state_t               w_state_nxt;
  logic [COUNTER_BITS-1:0] r_cnt;
  logic [2:0]              r_bit_idx;
  logic [7:0]              r_shift;
  logic                    w_fall;
  logic                    w_half;
  logic                    w_bit_end;
  logic                    w_sample;

  // Synchronizer and edge-detect history reset to the idle (high) line level,
  // so releasing reset on an idle line never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_line_prev <= 1'b1;
    end else begin
      r_sync1     <= i_serial;
      r_sync2     <= r_sync1;
      r_line_prev <= r_sync2;
    end
  end

  assign w_fall    = r_line_prev & ~r_sync2;
  assign w_half    = (r_cnt == HALF_LAST);
  assign w_bit_end = (r_cnt == BIT_LAST);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_state_nxt = RX_START;
      // Mid start bit: a line already back high was a glitch, drop it silently.
      RX_START: if (w_half) w_state_nxt = r_sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_state_nxt = RX_STOP;
      RX_STOP:  if (w_bit_end) w_state_nxt = RX_IDLE;
      default:  w_state_nxt = RX_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_sample    = 1'b0;
    o_byte_vld  = 1'b0;
    o_frame_err = 1'b0;
    case (r_state)
      RX_DATA: w_sample = w_bit_end;
      RX_STOP: begin
        o_byte_vld  = w_bit_end & r_sync2;
        o_frame_err = w_bit_end & ~r_sync2;
      end
      default: ;
    endcase
  end

  // Bit timing and data capture. The half-bit wait in START shifts every later
  // sample to the middle of its bit period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      if ((r_state == RX_IDLE) || (w_state_nxt != r_state) || w_bit_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state != RX_DATA) begin
        r_bit_idx <= 3'd0;
      end else if (w_sample) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end

      // LSB arrives first and ends up in bit 0 after eight shifts.
      if (w_sample) begin
        r_shift <= {r_sync2, r_shift[7:1]};
      end
    end
  end

  assign o_byte_dat = r_shift;

endmodule

// File: rtl/serial_uart.sv
// serial_uart: memory-mapped 8N1 UART -- DATA/STATUS registers, TX framer, RX via serial_rx.
// Latency: zero-cycle register reads; writes take effect on the next edge; TX start bit begins on the write edge.
// Backpressure: DATA writes while txBusy are dropped; an unread RX byte is overwritten and flagged as overrun.
// Ports: clk, reset (async active-low), address/select/strobe/write/dataIn (processor bus),
//        dataOut (read data), serialIn (RX line), serialOut (TX line, registered), rxReady (= rxFull).
module serial_uart
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int COUNTER_BITS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] address,
  input  logic       select,
  input  logic       strobe,
  input  logic       write,
  input  logic [7:0] dataIn,
  output logic [7:0] dataOut,
  input  logic       serialIn,
  output logic       serialOut,
  output logic       rxReady
);

  localparam logic [COUNTER_BITS-1:0] BIT_LAST = COUNTER_BITS'(CLKS_PER_BIT - 1);

  // Bus decode
  logic w_access;
  logic w_rd_data;
  logic w_wr_data;
  logic w_wr_status;

  assign w_access    = select & strobe;
  assign w_rd_data   = w_access & ~write & (address == ADDR_DATA);
  assign w_wr_data   = w_access &  write & (address == ADDR_DATA);
  assign w_wr_status = w_access &  write & (address == ADDR_STATUS);

  // ------------------------------------------------------------------
  // Receiver and RX-side status
  // ------------------------------------------------------------------
  logic       w_rx_vld;
  logic       w_rx_ferr;
  logic [7:0] w_rx_dat;
  logic [7:0] r_rx_hold;
  logic       r_rx_full;
  logic       r_overrun;
  logic       r_frame_err;

  serial_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .COUNTER_BITS (COUNTER_BITS)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .i_serial    (serialIn),
    .o_byte_vld  (w_rx_vld),
    .o_frame_err (w_rx_ferr),
    .o_byte_dat  (w_rx_dat)
  );

  // A completing byte beats a coincident DATA read: the new byte stays
  // pending, and since the old one was consumed it is not an overrun.
  // Error flags are sticky; a new error beats a clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_hold   <= 8'h00;
      r_rx_full   <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_rx_vld) begin
        r_rx_hold <= w_rx_dat;
        r_rx_full <= 1'b1;
      end else if (w_rd_data) begin
        r_rx_full <= 1'b0;
      end

      if (w_rx_vld && r_rx_full && !w_rd_data) begin
        r_overrun <= 1'b1;
      end else if (w_wr_status && dataIn[ST_OVERRUN]) begin
        r_overrun <= 1'b0;
      end

      if (w_rx_ferr) begin
        r_frame_err <= 1'b1;
      end else if (w_wr_status && dataIn[ST_FRAMEERR]) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  assign rxReady = r_rx_full;

  // ------------------------------------------------------------------
  // Transmitter
  // ------------------------------------------------------------------
  tx_state_t               r_tx_state;
  tx_state_t               w_tx_state_nxt;
  logic [COUNTER_BITS-1:0] r_tx_cnt;
  logic [2:0]              r_tx_bit_idx;
  logic [2:0]              w_tx_bit_nxt;
  logic [7:0]              r_tx_dat;
  logic                    r_serial_out;
  logic                    w_tx_line_nxt;
  logic                    w_tx_busy;
  logic                    w_tx_load;
  logic                    w_tx_bit_end;

  assign w_tx_busy    = (r_tx_state != TX_IDLE);
  assign w_tx_load    = w_wr_data & ~w_tx_busy;
  assign w_tx_bit_end = (r_tx_cnt == BIT_LAST);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_state <= TX_IDLE;
    end else begin
      r_tx_state <= w_tx_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    case (r_tx_state)
      TX_IDLE:  if (w_tx_load) w_tx_state_nxt = TX_START;
      TX_START: if (w_tx_bit_end) w_tx_state_nxt = TX_DATA;
      TX_DATA:  if (w_tx_bit_end && (r_tx_bit_idx == 3'd7)) w_tx_state_nxt = TX_STOP;
      TX_STOP:  if (w_tx_bit_end) w_tx_state_nxt = TX_IDLE;
      default:  w_tx_state_nxt = TX_IDLE;
    endcase
  end

  // Output logic: the line level for the *next* state is computed here and
  // registered, so serialOut changes exactly on state-entry edges and has no
  // combinational path from the bus.
  always_comb begin
    w_tx_bit_nxt  = 3'd0;
    w_tx_line_nxt = 1'b1;
    if (r_tx_state == TX_DATA) begin
      w_tx_bit_nxt = w_tx_bit_end ? (r_tx_bit_idx + 3'd1) : r_tx_bit_idx;
    end
    case (w_tx_state_nxt)
      TX_START: w_tx_line_nxt = 1'b0;
      TX_DATA:  w_tx_line_nxt = r_tx_dat[w_tx_bit_nxt];
      default:  w_tx_line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_cnt     <= '0;
      r_tx_bit_idx <= 3'd0;
      r_tx_dat     <= 8'h00;
      r_serial_out <= 1'b1;
    end else begin
      if ((r_tx_state == TX_IDLE) || w_tx_bit_end) begin
        r_tx_cnt <= '0;
      end else begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end
      r_tx_bit_idx <= w_tx_bit_nxt;
      if (w_tx_load) begin
        r_tx_dat <= dataIn;
      end
      r_serial_out <= w_tx_line_nxt;
    end
  end

  assign serialOut = r_serial_out;

  // ------------------------------------------------------------------
  // Read mux (combinational, ignores strobe)
  // ------------------------------------------------------------------
  logic [7:0] w_status;

  always_comb begin
    w_status              = 8'h00;
    w_status[ST_RXFULL]   = r_rx_full;
    w_status[ST_TXBUSY]   = w_tx_busy;
    w_status[ST_OVERRUN]  = r_overrun;
    w_status[ST_FRAMEERR] = r_frame_err;
  end

  always_comb begin
    case (address)
      ADDR_DATA:   dataOut = r_rx_hold;
      ADDR_STATUS: dataOut = w_status;
      default:     dataOut = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_serial_uart.sv
// tb_serial_uart: directed stimulus for serial_uart at 16 clocks per bit, with a
// frame-level model compared every cycle plus hand-computed literal expectations.
module tb_serial_uart;
  import uart_defs::*;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;
  // Line fall to rxFull: 2 synchronizer flops + edge detect, half a start bit,
  // then 8 data bits and the stop sample one bit period apart.
  localparam int RX_LAT = 3 + CPB / 2 + 9 * CPB;

  logic       clk;
  logic       reset;
  logic [3:0] address;
  logic       select;
  logic       strobe;
  logic       write;
  logic [7:0] dataIn;
  logic [7:0] dataOut;
  logic       serialIn;
  logic       serialOut;
  logic       rxReady;

  serial_uart #(
    .CLKS_PER_BIT (CPB),
    .COUNTER_BITS (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .select    (select),
    .strobe    (strobe),
    .write     (write),
    .dataIn    (dataIn),
    .dataOut   (dataOut),
    .serialIn  (serialIn),
    .serialOut (serialOut),
    .rxReady   (rxReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail < 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  typedef struct {
    int         t;
    logic [7:0] b;
    logic       stop;
  } rx_evt_t;

  rx_evt_t    rx_q[$];
  int         cyc      = 0;
  logic       m_full   = 1'b0;
  logic       m_ovr    = 1'b0;
  logic       m_ferr   = 1'b0;
  logic [7:0] m_hold   = 8'h00;
  int         tx_start = -100000;
  logic [7:0] tx_byte  = 8'h00;

  // TX line after edge n: start bit, LSB-first data, stop bit, each CPB cycles.
  function automatic logic exp_line(input int n);
    int d;
    d = n - tx_start;
    if (d < 0 || d >= FRAME) return 1'b1;
    if (d < CPB) return 1'b0;
    if (d >= 9 * CPB) return 1'b1;
    return tx_byte[d / CPB - 1];
  endfunction

  function automatic logic exp_busy(input int n);
    return (n - tx_start) >= 0 && (n - tx_start) < FRAME;
  endfunction

  always @(posedge clk) begin
    logic    rd, wd, ws, done;
    rx_evt_t e;
    cyc = cyc + 1;
    if (!reset) begin
      m_full = 0; m_ovr = 0; m_ferr = 0; m_hold = 8'h00;
      tx_start = -100000; tx_byte = 8'h00;
      rx_q.delete();
    end else begin
      rd   = select && strobe && !write && (address == ADDR_DATA);
      wd   = select && strobe &&  write && (address == ADDR_DATA);
      ws   = select && strobe &&  write && (address == ADDR_STATUS);
      done = 0;
      e.t = 0; e.b = 8'h00; e.stop = 1'b0;
      if (rx_q.size() > 0 && rx_q[0].t == cyc) begin
        done = 1;
        e = rx_q.pop_front();
      end
      if (ws && dataIn[ST_OVERRUN])  m_ovr  = 0;
      if (ws && dataIn[ST_FRAMEERR]) m_ferr = 0;
      if (done && e.stop) begin
        if (m_full && !rd) m_ovr = 1;
        m_hold = e.b;
        m_full = 1;
      end else if (rd) begin
        m_full = 0;
      end
      if (done && !e.stop) m_ferr = 1;
      if (wd && !exp_busy(cyc - 1)) begin
        tx_start = cyc;
        tx_byte  = dataIn;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [7:0] st, exp_do;
    if (!reset) begin
      check("rst_serialOut", serialOut, 1);
      check("rst_rxReady", rxReady, 0);
      check("rst_dataOut", dataOut, 8'h00);
    end else begin
      check("cyc_serialOut", serialOut, exp_line(cyc));
      check("cyc_rxReady", rxReady, m_full);
      st = {4'h0, m_ferr, m_ovr, exp_busy(cyc), m_full};
      exp_do = (address == ADDR_DATA) ? m_hold : (address == ADDR_STATUS) ? st : 8'h00;
      check("cyc_dataOut", dataOut, exp_do);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] mem, input logic [7:0] d);
    select = is_uart_addr(mem); strobe = 1; write = 1; address = mem[3:0]; dataIn = d;
    tick();
    select = 0; strobe = 0; write = 0; address = ADDR_STATUS; dataIn = 8'h00;
  endtask

  task automatic bus_read(input logic [15:0] mem, output logic [7:0] d);
    select = is_uart_addr(mem); strobe = 1; write = 0; address = mem[3:0];
    #1;
    d = dataOut;
    tick();
    select = 0; strobe = 0; address = ADDR_STATUS;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit pin);
    logic [9:0] bits;
    rx_evt_t    ev;
    bits    = {stop, b, 1'b0};
    ev.t    = cyc + RX_LAT;
    ev.b    = b;
    ev.stop = stop;
    rx_q.push_back(ev);
    for (int c = 0; c < FRAME; c++) begin
      serialIn = bits[c / CPB];
      if (pin && c == RX_LAT - 1) check("rx_rise_before", rxReady, 0);
      if (pin && c == RX_LAT)     check("rx_rise_at", rxReady, 1);
      tick();
    end
    serialIn = 1;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] v;
    logic [9:0] seq_3c;
    logic [9:0] seq_c3;
    seq_3c = 10'b1001111000;  // transmitted order 0,0,0,1,1,1,1,0,0,1 read from bit 0
    seq_c3 = 10'b1110000110;  // transmitted order 0,1,1,0,0,0,0,1,1,1

    reset = 0; serialIn = 1; select = 0; strobe = 0; write = 0;
    address = ADDR_STATUS; dataIn = 8'h00;
    repeat (3) tick();
    check("reset_serialOut", serialOut, 1);
    check("reset_rxReady", rxReady, 0);
    check("reset_status", dataOut, 8'h00);
    address = ADDR_DATA; #1;
    check("reset_data", dataOut, 8'h00);
    address = ADDR_STATUS;
    reset = 1;
    repeat (4) tick();

    // RX 0xA5, rise timing pinned inside send_frame
    send_frame(8'hA5, 1'b1, 1'b1);
    bus_read(16'h0120, v);  // strobe without select: no side effect
    check("unselected_keeps_full", rxReady, 1);
    bus_read(16'h7F10, v);
    check("rx_a5_data", v, 8'hA5);
    check("rx_a5_cleared", rxReady, 0);
    repeat (4) tick();

    // TX 0x3C
    bus_write(16'h7F10, 8'h3C);
    repeat (CPB / 2) tick();
    for (int k = 0; k < 10; k++) begin
      check("tx_3c_bit", serialOut, seq_3c[k]);
      check("tx_3c_busy", dataOut[ST_TXBUSY], 1);
      repeat (CPB) tick();
    end
    check("tx_3c_idle_busy", dataOut[ST_TXBUSY], 0);
    check("tx_3c_idle_line", serialOut, 1);

    // Overrun: two frames, no read in between
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    bus_read(16'h7F11, v);
    check("ovr_status", v, 8'h05);
    bus_write(16'h7F11, 8'h04);
    bus_read(16'h7F11, v);
    check("ovr_cleared_status", v, 8'h01);
    bus_read(16'h7F10, v);
    check("ovr_data", v, 8'h22);
    bus_read(16'h7F11, v);
    check("ovr_after_read", v, 8'h00);

    // Framing error, then clear it
    send_frame(8'h55, 1'b0, 1'b0);
    bus_read(16'h7F11, v);
    check("ferr_status", v, 8'h08);
    check("ferr_rxReady", rxReady, 0);
    bus_write(16'h7F11, 8'h08);
    bus_read(16'h7F11, v);
    check("ferr_cleared", v, 8'h00);

    // 4-cycle glitch, then a good frame proves the receiver is back in idle
    serialIn = 0;
    repeat (4) tick();
    serialIn = 1;
    repeat (40) tick();
    bus_read(16'h7F11, v);
    check("glitch_status", v, 8'h00);
    check("glitch_rxReady", rxReady, 0);
    send_frame(8'h5A, 1'b1, 1'b0);
    bus_read(16'h7F10, v);
    check("after_glitch_data", v, 8'h5A);

    // DATA write during an active frame is dropped
    bus_write(16'h7F10, 8'hC3);
    repeat (50) tick();
    bus_write(16'h7F10, 8'h81);
    repeat (5) tick();
    for (int k = 3; k < 10; k++) begin
      check("tx_c3_bit", serialOut, seq_c3[k]);
      repeat (CPB) tick();
    end
    check("tx_c3_done", dataOut[ST_TXBUSY], 0);
    repeat (20) tick();
    check("tx_81_not_sent", serialOut, 1);

    // Reset mid-frame
    bus_write(16'h7F10, 8'h0F);
    repeat (60) tick();
    reset = 0;
    #1;
    check("midtx_reset_line", serialOut, 1);
    check("midtx_reset_status", dataOut, 8'h00);
    check("midtx_reset_rxReady", rxReady, 0);
    repeat (3) tick();
    reset = 1;
    repeat (20) tick();
    check("after_reset_line", serialOut, 1);
    check("after_reset_status", dataOut, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
